// File: rtl/stepper_pkg.sv
// Shared state encoding and position-flag codes for the stepper motion path.
// Also used by the coil-pattern driver.
package stepper_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEL  = 3'd1,
        CRUISE = 3'd2,
        DECEL  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [1:0] FLAG_HOME  = 2'b00;
    localparam logic [1:0] FLAG_LIMIT = 2'b01;
    localparam logic [1:0] FLAG_MID   = 2'b10;

    function automatic logic [1:0] pos_flag(input int unsigned pos, input int unsigned limit);
        if (pos == 0) return FLAG_HOME;
        if (pos >= limit) return FLAG_LIMIT;
        return FLAG_MID;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable step-period down-counter; o_expire_c is high for the single cycle
// in which the count sits at 1, so a load of N yields expiry N cycles later.
module step_timer #(
    parameter int unsigned P_PER_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [P_PER_W-1:0] i_load_val,
    output logic               o_expire_c
);

    logic [P_PER_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - P_PER_W'(1);
        end
    end

    assign o_expire_c = (r_cnt == P_PER_W'(1));

endmodule

// File: rtl/stepper_move_ctrl.sv
// Absolute-position motion sequencer: accepts target commands and emits ramped
// step/dir pulses to the coil driver while tracking position and travel status.
module stepper_move_ctrl
    import stepper_pkg::*;
#(
    parameter int unsigned P_COUNT_LIMIT = 200,
    parameter int unsigned P_POS_W       = 8,
    parameter int unsigned P_PER_W       = 16,
    parameter int unsigned P_PER_START   = 1000,
    parameter int unsigned P_PER_MIN     = 200,
    parameter int unsigned P_PER_DELTA   = 100
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [P_POS_W-1:0] i_cmd_target,
    input  logic               i_abort,
    output logic               o_step,
    output logic               o_dir,
    output logic [P_POS_W-1:0] o_pos,
    output logic [1:0]         o_pos_flag,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [P_POS_W-1:0] C_LIMIT = P_POS_W'(P_COUNT_LIMIT);
    localparam logic [P_PER_W-1:0] C_START = P_PER_W'(P_PER_START);
    localparam logic [P_PER_W-1:0] C_MIN   = P_PER_W'(P_PER_MIN);
    localparam logic [P_PER_W-1:0] C_DELTA = P_PER_W'(P_PER_DELTA);

    state_t             r_state, w_state_nxt;
    logic [P_POS_W-1:0] r_pos, w_pos_nxt;
    logic [P_POS_W-1:0] r_rem, w_rem_nxt;
    logic [P_POS_W-1:0] r_ramp, w_ramp_nxt;
    logic [P_PER_W-1:0] r_per, w_per_nxt;
    logic               r_dir, w_dir_nxt;
    logic               r_step, w_step_nxt;
    logic               r_done, w_done_nxt;
    logic               r_busy, r_ready;
    logic [1:0]         r_flag;

    logic               w_zero_move;
    logic               w_load;
    logic [P_PER_W-1:0] w_load_val;
    logic               w_expire;
    logic               w_blocked;
    logic [P_POS_W-1:0] w_tgt;
    logic [P_POS_W-1:0] w_abort_cap;
    logic [P_PER_W-1:0] w_per_dn, w_per_up;

    step_timer #(.P_PER_W(P_PER_W)) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire_c (w_expire)
    );

    // Next-state, datapath and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_rem_nxt   = r_rem;
        w_ramp_nxt  = r_ramp;
        w_per_nxt   = r_per;
        w_dir_nxt   = r_dir;
        w_step_nxt  = 1'b0;
        w_zero_move = 1'b0;
        w_load      = 1'b0;
        w_load_val  = C_START;
        w_abort_cap = '0;

        w_tgt     = (i_cmd_target > C_LIMIT) ? C_LIMIT : i_cmd_target;
        w_blocked = r_dir ? (r_pos >= C_LIMIT) : (r_pos == '0);
        w_per_dn  = (r_per > C_DELTA && (r_per - C_DELTA) > C_MIN) ? r_per - C_DELTA : C_MIN;
        w_per_up  = (r_per < C_START && (C_START - r_per) > C_DELTA) ? r_per + C_DELTA : C_START;

        unique case (r_state)
            IDLE: begin
                if (i_cmd_valid) begin
                    if (w_tgt == r_pos) begin
                        w_zero_move = 1'b1;
                    end else begin
                        w_dir_nxt   = (w_tgt > r_pos);
                        w_rem_nxt   = (w_tgt > r_pos) ? w_tgt - r_pos : r_pos - w_tgt;
                        w_ramp_nxt  = '0;
                        w_per_nxt   = C_START;
                        w_load      = 1'b1;
                        w_load_val  = C_START;
                        w_state_nxt = ACCEL;
                    end
                end
            end
            ACCEL, CRUISE, DECEL: begin
                if (w_expire) begin
                    // A step that would leave the travel range is suppressed and ends the move
                    if (w_blocked) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_step_nxt = 1'b1;
                        w_pos_nxt  = r_dir ? r_pos + P_POS_W'(1) : r_pos - P_POS_W'(1);
                        w_rem_nxt  = r_rem - P_POS_W'(1);
                        if (r_state == ACCEL) begin
                            w_per_nxt  = w_per_dn;
                            w_ramp_nxt = (r_ramp == '1) ? r_ramp : r_ramp + P_POS_W'(1);
                        end else if (r_state == DECEL) begin
                            w_per_nxt  = w_per_up;
                            w_ramp_nxt = (r_ramp == '0) ? r_ramp : r_ramp - P_POS_W'(1);
                        end
                        if (w_rem_nxt == '0) begin
                            w_state_nxt = DONE;
                        end else if (r_state != DECEL && w_rem_nxt <= w_ramp_nxt) begin
                            w_state_nxt = DECEL;
                        end else if (r_state == ACCEL && w_per_nxt == C_MIN) begin
                            w_state_nxt = CRUISE;
                        end
                        w_load     = (w_rem_nxt != '0);
                        w_load_val = w_per_nxt;
                    end
                end
                // Abort keeps the step already being timed, then ramps down over the built-up ramp
                if (i_abort && w_state_nxt != DONE) begin
                    w_abort_cap = (w_ramp_nxt == '0) ? P_POS_W'(1) : w_ramp_nxt;
                    if (w_rem_nxt > w_abort_cap) w_rem_nxt = w_abort_cap;
                    w_state_nxt = DECEL;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_done_nxt = (w_state_nxt == DONE) || w_zero_move;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_pos   <= '0;
            r_rem   <= '0;
            r_ramp  <= '0;
            r_per   <= C_START;
            r_dir   <= 1'b1;
            r_step  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_flag  <= FLAG_HOME;
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
            r_rem   <= w_rem_nxt;
            r_ramp  <= w_ramp_nxt;
            r_per   <= w_per_nxt;
            r_dir   <= w_dir_nxt;
            r_step  <= w_step_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_ready <= (w_state_nxt == IDLE);
            r_flag  <= pos_flag(32'(w_pos_nxt), P_COUNT_LIMIT);
        end
    end

    assign o_cmd_ready = r_ready;
    assign o_step      = r_step;
    assign o_dir       = r_dir;
    assign o_pos       = r_pos;
    assign o_pos_flag  = r_flag;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Directed bench for stepper_move_ctrl with step periods scaled down by ten
// (start 100, cruise 20, delta 10) so full-travel moves stay short.
module tb_stepper_move_ctrl;

    localparam int unsigned LIMIT = 200;
    localparam int unsigned START = 100;
    localparam int unsigned PMIN  = 20;
    localparam int unsigned DELTA = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [7:0] cmd_target;
    logic       abort;
    logic       cmd_ready, step, dir, busy, done;
    logic [7:0] pos;
    logic [1:0] pos_flag;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int step_t[$];
    int fwd_cnt = 0;
    int rev_cnt = 0;
    int done_cnt = 0;

    stepper_move_ctrl #(
        .P_COUNT_LIMIT(LIMIT), .P_POS_W(8), .P_PER_W(16),
        .P_PER_START(START), .P_PER_MIN(PMIN), .P_PER_DELTA(DELTA)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_target(cmd_target), .i_abort(abort), .o_step(step), .o_dir(dir),
        .o_pos(pos), .o_pos_flag(pos_flag), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (step) begin
            step_t.push_back(cyc);
            if (dir) fwd_cnt++;
            else rev_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        step_t.delete();
        fwd_cnt = 0;
        rev_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic send_cmd(input logic [7:0] tgt, output int t_acc);
        cmd_valid = 1'b1;
        cmd_target = tgt;
        tick();
        t_acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: o_done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_steps(input string name, input int n, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (step_t.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_steps_timeout: got %0d steps, wanted %0d", name, step_t.size(), n);
        end
    endtask

    task automatic check_interval(input string name, input int idx, input int t_acc, input int exp_iv);
        int iv;
        checks++;
        if (idx >= step_t.size()) begin
            errors++;
            $display("FAIL %s_iv%0d: step missing, exp interval %0d", name, idx, exp_iv);
        end else begin
            iv = (idx == 0) ? step_t[0] - t_acc : step_t[idx] - step_t[idx-1];
            if (iv !== exp_iv) begin
                errors++;
                $display("FAIL %s_iv%0d: got %0d exp %0d", name, idx, iv, exp_iv);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_target = '0;
        abort = 1'b0;
        repeat (3) tick();
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b exp 0", step); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL reset_dir: got %b exp 1", dir); end
        checks++; if (pos !== 8'd0) begin errors++; $display("FAIL reset_pos: got %0d exp 0", pos); end
        checks++; if (pos_flag !== 2'b00) begin errors++; $display("FAIL reset_flag: got %b exp 00", pos_flag); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", cmd_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_move10();
        int t_acc;
        int exp_iv[10] = '{100, 90, 80, 70, 60, 50, 60, 70, 80, 90};
        clear_mon();
        send_cmd(8'd10, t_acc);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL move10_busy: got %b exp 1", busy); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL move10_ready: got %b exp 0", cmd_ready); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL move10_dir: got %b exp 1", dir); end
        // A command offered mid-move must be ignored
        cmd_valid = 1'b1;
        cmd_target = 8'd0;
        repeat (5) tick();
        cmd_valid = 1'b0;
        wait_done("move10", 2000);
        checks++; if (step_t.size() !== 10) begin errors++; $display("FAIL move10_count: got %0d exp 10", step_t.size()); end
        for (int i = 0; i < 10; i++) check_interval("move10", i, t_acc, exp_iv[i]);
        checks++; if (pos !== 8'd10) begin errors++; $display("FAIL move10_pos: got %0d exp 10", pos); end
        checks++; if (pos_flag !== 2'b10) begin errors++; $display("FAIL move10_flag: got %b exp 10", pos_flag); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL move10_done_cnt: got %0d exp 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL move10_busy_end: got %b exp 0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL move10_ready_end: got %b exp 1", cmd_ready); end
    endtask

    task automatic test_return();
        int t_acc;
        int exp_iv[10] = '{100, 90, 80, 70, 60, 50, 60, 70, 80, 90};
        clear_mon();
        send_cmd(8'd0, t_acc);
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL return_dir: got %b exp 0", dir); end
        wait_done("return", 2000);
        checks++; if (rev_cnt !== 10) begin errors++; $display("FAIL return_rev: got %0d exp 10", rev_cnt); end
        for (int i = 0; i < 10; i++) check_interval("return", i, t_acc, exp_iv[i]);
        checks++; if (pos !== 8'd0) begin errors++; $display("FAIL return_pos: got %0d exp 0", pos); end
        checks++; if (pos_flag !== 2'b00) begin errors++; $display("FAIL return_flag: got %b exp 00", pos_flag); end
    endtask

    task automatic test_full_fwd();
        int t_acc;
        clear_mon();
        send_cmd(8'd200, t_acc);
        wait_done("full_fwd", 6000);
        checks++; if (step_t.size() !== 200) begin errors++; $display("FAIL full_fwd_count: got %0d exp 200", step_t.size()); end
        checks++; if (fwd_cnt !== 200) begin errors++; $display("FAIL full_fwd_dir: got %0d fwd steps exp 200", fwd_cnt); end
        check_interval("full_fwd", 0, t_acc, 100);
        check_interval("full_fwd", 7, t_acc, 30);
        check_interval("full_fwd", 8, t_acc, 20);
        check_interval("full_fwd", 100, t_acc, 20);
        check_interval("full_fwd", 192, t_acc, 20);
        check_interval("full_fwd", 193, t_acc, 30);
        check_interval("full_fwd", 199, t_acc, 90);
        checks++; if (pos !== 8'd200) begin errors++; $display("FAIL full_fwd_pos: got %0d exp 200", pos); end
        checks++; if (pos_flag !== 2'b01) begin errors++; $display("FAIL full_fwd_flag: got %b exp 01", pos_flag); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL full_fwd_done_cnt: got %0d exp 1", done_cnt); end
    endtask

    task automatic test_clamp();
        int t_acc;
        clear_mon();
        send_cmd(8'd255, t_acc);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL clamp_done: got %b exp 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clamp_busy: got %b exp 0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL clamp_ready: got %b exp 1", cmd_ready); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL clamp_done_len: got %b exp 0", done); end
        repeat (150) tick();
        checks++; if (step_t.size() !== 0) begin errors++; $display("FAIL clamp_steps: got %0d exp 0", step_t.size()); end
        checks++; if (pos !== 8'd200) begin errors++; $display("FAIL clamp_pos: got %0d exp 200", pos); end
    endtask

    task automatic test_full_rev();
        int t_acc;
        clear_mon();
        send_cmd(8'd0, t_acc);
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL full_rev_dir: got %b exp 0", dir); end
        wait_done("full_rev", 6000);
        checks++; if (rev_cnt !== 200) begin errors++; $display("FAIL full_rev_count: got %0d exp 200", rev_cnt); end
        checks++; if (fwd_cnt !== 0) begin errors++; $display("FAIL full_rev_fwd: got %0d exp 0", fwd_cnt); end
        checks++; if (pos !== 8'd0) begin errors++; $display("FAIL full_rev_pos: got %0d exp 0", pos); end
        checks++; if (pos_flag !== 2'b00) begin errors++; $display("FAIL full_rev_flag: got %b exp 00", pos_flag); end
    endtask

    task automatic test_one_step();
        int t_acc;
        clear_mon();
        send_cmd(8'd1, t_acc);
        wait_done("one_step", 1000);
        checks++; if (step_t.size() !== 1) begin errors++; $display("FAIL one_step_count: got %0d exp 1", step_t.size()); end
        check_interval("one_step", 0, t_acc, 100);
        checks++; if (pos !== 8'd1) begin errors++; $display("FAIL one_step_pos: got %0d exp 1", pos); end
        checks++; if (pos_flag !== 2'b10) begin errors++; $display("FAIL one_step_flag: got %b exp 10", pos_flag); end
    endtask

    task automatic test_abort();
        int t_acc;
        logic [7:0] p_abort;
        int exp_iv[8] = '{20, 30, 40, 50, 60, 70, 80, 90};
        clear_mon();
        send_cmd(8'd150, t_acc);
        wait_steps("abort", 12, 2000);
        p_abort = pos;
        checks++; if (p_abort !== 8'd13) begin errors++; $display("FAIL abort_pos_at: got %0d exp 13", p_abort); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("abort", 2000);
        checks++; if (step_t.size() !== 20) begin errors++; $display("FAIL abort_count: got %0d exp 20", step_t.size()); end
        for (int i = 0; i < 8; i++) check_interval("abort", 12 + i, t_acc, exp_iv[i]);
        checks++; if (pos !== 8'd21) begin errors++; $display("FAIL abort_pos: got %0d exp 21", pos); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL abort_done_cnt: got %0d exp 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        int t_acc;
        int n_at_rst;
        int exp_iv[3] = '{100, 90, 80};
        clear_mon();
        send_cmd(8'd60, t_acc);
        wait_steps("reset_mid", 3, 2000);
        rst_n = 1'b0;
        #1;
        n_at_rst = step_t.size();
        checks++; if (pos !== 8'd0) begin errors++; $display("FAIL reset_mid_pos: got %0d exp 0", pos); end
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_mid_step: got %b exp 0", step); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b exp 0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %b exp 1", cmd_ready); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL reset_mid_dir: got %b exp 1", dir); end
        checks++; if (pos_flag !== 2'b00) begin errors++; $display("FAIL reset_mid_flag: got %b exp 00", pos_flag); end
        repeat (150) tick();
        checks++; if (step_t.size() !== n_at_rst) begin errors++; $display("FAIL reset_mid_glitch: got %0d steps exp %0d", step_t.size(), n_at_rst); end
        rst_n = 1'b1;
        tick();
        clear_mon();
        send_cmd(8'd3, t_acc);
        wait_done("after_reset", 1000);
        checks++; if (step_t.size() !== 3) begin errors++; $display("FAIL after_reset_count: got %0d exp 3", step_t.size()); end
        for (int i = 0; i < 3; i++) check_interval("after_reset", i, t_acc, exp_iv[i]);
        checks++; if (pos !== 8'd3) begin errors++; $display("FAIL after_reset_pos: got %0d exp 3", pos); end
    endtask

    initial begin
        test_reset();
        test_move10();
        test_return();
        test_full_fwd();
        test_clamp();
        test_full_rev();
        test_one_step();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
